// File: rtl/kmul_arbiter_if.sv
// -----------------------------------------------------------------------------
// kmul_arbiter_if
//   Bundles every signal of kmul_arbiter except clk/rst: the requester
//   channels, the multiplier start/operand/product lines and the response
//   channel.
//
//   Parameters:
//     NREQ  number of requesters
//     IDW   requester ID width
//
//   Signals:
//     req_valid [NREQ]     per-requester operand valid          (to arbiter)
//     req_ready [NREQ]     per-requester accept, one-hot/zero   (from arbiter)
//     req_a/req_b [64*NREQ] operands, requester i at [64i+63:64i] (to arbiter)
//     mul_start            one-cycle multiplier start pulse     (from arbiter)
//     mul_a/mul_b [64]     registered multiplier operands       (from arbiter)
//     mul_p [128]          multiplier product                   (to arbiter)
//     mul_valid            multiplier valid_out                 (to arbiter)
//     rsp_valid/rsp_ready  response handshake
//     rsp_id [IDW]         owner of the product                 (from arbiter)
//     rsp_p [128]          product                              (from arbiter)
//     rsp_err              timeout abort flag                   (from arbiter)
//     busy                 arbiter not idle                     (from arbiter)
//
//   Modports:
//     slave   the arbiter itself
//     master  the surrounding environment (requesters, multiplier, sink)
// -----------------------------------------------------------------------------
interface kmul_arbiter_if #(
  parameter int NREQ = 2,
  parameter int IDW  = 3
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [64*NREQ-1:0]   req_a;
  logic [64*NREQ-1:0]   req_b;
  logic                 mul_start;
  logic [63:0]          mul_a;
  logic [63:0]          mul_b;
  logic [127:0]         mul_p;
  logic                 mul_valid;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic [127:0]         rsp_p;
  logic                 rsp_err;
  logic                 busy;

  modport slave (
    input  req_valid, req_a, req_b, mul_p, mul_valid, rsp_ready,
    output req_ready, mul_start, mul_a, mul_b, rsp_valid, rsp_id, rsp_p,
           rsp_err, busy
  );

  modport master (
    output req_valid, req_a, req_b, mul_p, mul_valid, rsp_ready,
    input  req_ready, mul_start, mul_a, mul_b, rsp_valid, rsp_id, rsp_p,
           rsp_err, busy
  );
endinterface

// File: rtl/kmul_arbiter.sv
// -----------------------------------------------------------------------------
// kmul_arbiter
//   Shares a single karatsuba64 multiplier between NREQ requesters.
//   Round-robin grant in IDLE, registered operands plus a one-cycle start
//   pulse in ISSUE, wait for the multiplier valid in WAIT, and hold the
//   128-bit product with the owner's ID on a valid/ready channel in RESP.
//   Only one multiplication is ever in flight.
//
//   Parameters:
//     NREQ         number of requesters (2..8)
//     IDW          requester ID width, 2**IDW >= NREQ
//     TIMEOUT_CYC  maximum WAIT cycles before an abort (optional feature)
//
//   Ports:
//     clk   clock
//     rst   asynchronous, active-high reset
//     bus   kmul_arbiter_if.slave (requests, multiplier link, response)
//
//   Build option:
//     KMUL_ARB_TIMEOUT_EN  when defined, WAIT aborts after TIMEOUT_CYC cycles
//                          with rsp_err=1 and rsp_p=0. When undefined, no
//                          counter exists, WAIT is unbounded and rsp_err=0.
// -----------------------------------------------------------------------------
module kmul_arbiter #(
  parameter int NREQ        = 2,
  parameter int IDW         = 3,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic           clk,
  input  logic           rst,
  kmul_arbiter_if.slave  bus
);

  if (NREQ < 2 || NREQ > 8 || (2 ** IDW) < NREQ || TIMEOUT_CYC < 1) begin : g_param_check
    $error("kmul_arbiter: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            mul_start_q, mul_start_d;
  logic [63:0]     mul_a_q, mul_a_d;
  logic [63:0]     mul_b_q, mul_b_d;
  logic [IDW-1:0]  cur_id_q, cur_id_d;
  logic [IDW-1:0]  last_grant_q, last_grant_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [127:0]    rsp_p_q, rsp_p_d;

`ifdef KMUL_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  logic            rsp_err_q, rsp_err_d;
  logic [CW-1:0]   tmo_q, tmo_d;
  logic            tmo_hit;

  assign tmo_hit = (tmo_q == CW'(TIMEOUT_CYC - 1));
`endif

  // ---------------------------------------------------------------------------
  // Round-robin grant: candidates are visited in order last_grant+1,
  // last_grant+2, ... modulo NREQ. The inner loop compares against constant
  // indices so every req_valid bit select stays in range.
  // ---------------------------------------------------------------------------
  logic            grant_found;
  logic [IDW-1:0]  grant_idx;
  logic [IDW:0]    cand;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = {1'b0, last_grant_q} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) begin
        cand = cand - (IDW+1)'(NREQ);
      end
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!grant_found && (cand == (IDW+1)'(i)) && bus.req_valid[i]) begin
          grant_found = 1'b1;
          grant_idx   = IDW'(i);
        end
      end
    end
  end

  // Operand select for the granted requester
  logic [63:0] sel_a, sel_b;

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_idx == IDW'(i)) begin
        sel_a = bus.req_a[64*i +: 64];
        sel_b = bus.req_b[64*i +: 64];
      end
    end
  end

  // req_ready is one-hot on the grant, and only while IDLE
  logic [NREQ-1:0] req_ready_c;

  always_comb begin
    req_ready_c = '0;
    if (state_q == IDLE && grant_found) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (grant_idx == IDW'(i)) begin
          req_ready_c[i] = 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state / datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    mul_start_d  = 1'b0;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    cur_id_d     = cur_id_q;
    last_grant_d = last_grant_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_p_d      = rsp_p_q;
`ifdef KMUL_ARB_TIMEOUT_EN
    rsp_err_d    = rsp_err_q;
    tmo_d        = tmo_q;
`endif

    case (state_q)
      IDLE: begin
        // A found grant is always a handshake: req_ready mirrors it.
        if (grant_found) begin
          mul_a_d      = sel_a;
          mul_b_d      = sel_b;
          cur_id_d     = grant_idx;
          last_grant_d = grant_idx;
          mul_start_d  = 1'b1;
          state_d      = ISSUE;
        end
      end

      ISSUE: begin
        state_d = WAIT;
`ifdef KMUL_ARB_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end

      WAIT: begin
        if (bus.mul_valid) begin
          rsp_p_d     = bus.mul_p;
          rsp_id_d    = cur_id_q;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
`ifdef KMUL_ARB_TIMEOUT_EN
          rsp_err_d   = 1'b0;
        end else if (tmo_hit) begin
          rsp_p_d     = '0;
          rsp_id_d    = cur_id_q;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          tmo_d       = tmo_q + CW'(1);
`endif
        end
      end

      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      mul_start_q  <= 1'b0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      cur_id_q     <= '0;
      last_grant_q <= IDW'(NREQ - 1);
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_p_q      <= '0;
`ifdef KMUL_ARB_TIMEOUT_EN
      rsp_err_q    <= 1'b0;
      tmo_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      mul_start_q  <= mul_start_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      cur_id_q     <= cur_id_d;
      last_grant_q <= last_grant_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_p_q      <= rsp_p_d;
`ifdef KMUL_ARB_TIMEOUT_EN
      rsp_err_q    <= rsp_err_d;
      tmo_q        <= tmo_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.req_ready = req_ready_c;
  assign bus.mul_start = mul_start_q;
  assign bus.mul_a     = mul_a_q;
  assign bus.mul_b     = mul_b_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_p     = rsp_p_q;
  assign bus.busy      = (state_q != IDLE);
`ifdef KMUL_ARB_TIMEOUT_EN
  assign bus.rsp_err   = rsp_err_q;
`else
  assign bus.rsp_err   = 1'b0;
`endif

endmodule
